bus_slave_mem: RTL and testbench
================================

BUS_SLAVE_MEM -- requirements
Module: bus_slave_mem

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64, meaning number of 32-bit words implemented (legal 1..256).
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, meaning wait states between request acceptance and grant (legal 0..15).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port req, input, 1, master request; held high until gnt.
REQ-006 The block SHALL have port addr, input, 8, word address; stable while req high.
REQ-007 The block SHALL have port wdata, input, 32, write data; stable while req high.
REQ-008 The block SHALL have port wr_en, input, 1, 1 = write and 0 = read; stable while req high.
REQ-009 The block SHALL have port gnt, output, 1, one-cycle grant pulse completing the transfer.
REQ-010 The block SHALL have port rdata, output, 32, read data, valid in the gnt cycle.

Function
REQ-011 The block SHALL implement FSM states IDLE, WAIT and GRANT.
REQ-012 In IDLE with req=1, the FSM SHALL go to GRANT if WAIT_CYCLES=0, else go to WAIT and load the wait counter with WAIT_CYCLES.
REQ-013 In WAIT, the counter SHALL decrement each cycle, and the FSM SHALL go to GRANT on the edge where the counter equals 1.
REQ-014 gnt SHALL be high exactly while in GRANT, so it rises WAIT_CYCLES+1 cycles after the first edge sampling req=1.
REQ-015 GRANT SHALL always go to IDLE, giving at least one idle cycle between transfers; req still high in IDLE starts a new transfer.
REQ-016 If req drops while in WAIT, the FSM SHALL return to IDLE with no gnt, no write and no counter update.
REQ-017 A write (wr_en=1) SHALL update mem[addr] with wdata on the edge entering GRANT, so a read in the next transfer sees the new value.
REQ-018 For a read (wr_en=0), rdata SHALL be registered from mem[addr] on the edge entering GRANT and held until the next read grant.
REQ-019 An addr >= DEPTH SHALL drop the write (still granted), and a read of it SHALL return 32'hDEAD_BEEF.
REQ-020 Write transfers SHALL leave rdata unchanged.

Reset
REQ-021 rst_n=0 SHALL immediately force state=IDLE, gnt=0, rdata=0, wait counter=0, all DEPTH words=0, and statistics counters=0.
REQ-022 Reset asserted mid-transfer SHALL abort the transfer with no write.
REQ-023 After rst_n rises, the first edge SHALL sample req normally.

Configuration
REQ-024 With macro BUS_SLAVE_MEM_STATS_EN defined, the block SHALL add output ports rd_cnt[15:0] and wr_cnt[15:0].
REQ-025 With BUS_SLAVE_MEM_STATS_EN defined, rd_cnt and wr_cnt SHALL count granted reads and writes (out-of-range included), incrementing on the edge entering GRANT and saturating at 16'hFFFF.
REQ-026 Without BUS_SLAVE_MEM_STATS_EN, the ports and counters SHALL be absent, with all other behaviour identical.

Verification
REQ-027 Reset then write addr=8'h05 wdata=32'hA5A5_0001 with WAIT_CYCLES=2 -> gnt high 3 cycles after req sampled, for exactly 1 cycle; then a read of 8'h05 returns 32'hA5A5_0001 in its gnt cycle.
REQ-028 WAIT_CYCLES=0 with back-to-back reads of 8'h00 and 8'h01 (req held high) -> gnt on cycles 1 and 3, with one idle cycle between; rdata=0 after reset.
REQ-029 DEPTH=64: write 8'h40=32'h1234_5678, then read 8'h40 -> gnt for both, rdata=32'hDEAD_BEEF; read 8'h00 stays 0.
REQ-030 req dropped in the second WAIT cycle of a write to 8'h02 -> no gnt; a later read of 8'h02 returns 0.
REQ-031 rst_n pulsed low during WAIT of a write -> gnt=0 immediately, memory word unchanged at 0, FSM in IDLE.
REQ-032 With BUS_SLAVE_MEM_STATS_EN: 3 writes + 2 reads -> wr_cnt=3 and rd_cnt=2; with wr_cnt preloaded near saturation, 70000 writes -> wr_cnt=16'hFFFF.

Source files
------------

// File: rtl/bus_slave_mem.sv
// Word-addressed bus slave memory with a programmable wait-state FSM.
// Define BUS_SLAVE_MEM_STATS_EN to add saturating read/write grant counters.
module bus_slave_mem #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  input  logic        wr_en,
  output logic        gnt,
  output logic [31:0] rdata
`ifdef BUS_SLAVE_MEM_STATS_EN
  ,
  output logic [15:0] rd_cnt,
  output logic [15:0] wr_cnt
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] GRANT = 2'd2;

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WC = 4'(WAIT_CYCLES);
  localparam logic [31:0] OOR_DATA = 32'hDEAD_BEEF;

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   mem_q [DEPTH];
  logic          take;
  logic          in_rng;
  logic [AW-1:0] idx;

  assign in_rng = ({24'd0, addr} < 32'(DEPTH));
  assign idx    = addr[AW-1:0];

  // take marks the edge that enters GRANT: the single commit point
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    take    = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (req) begin
          if (WC == 4'd0) begin
            state_d = GRANT;
            take    = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = WC;
          end
        end
      end
      (state_q == WAIT): begin
        if (!req) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd1) begin
          state_d = GRANT;
          cnt_d   = 4'd0;
          take    = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      (state_q == GRANT): begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    if (take && !wr_en) begin
      rdata_d = in_rng ? mem_q[idx] : OOR_DATA;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'd0;
      end
    end else if (take && wr_en && in_rng) begin
      mem_q[idx] <= wdata;
    end
  end

  assign gnt   = (state_q == GRANT);
  assign rdata = rdata_q;

`ifdef BUS_SLAVE_MEM_STATS_EN
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (take && !wr_en && rd_cnt_q != 16'hFFFF) begin
      rd_cnt_d = rd_cnt_q + 16'd1;
    end
    if (take && wr_en && wr_cnt_q != 16'hFFFF) begin
      wr_cnt_d = wr_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_q <= 16'd0;
      wr_cnt_q <= 16'd0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
`endif

endmodule

// File: tb/tb_bus_slave_mem.sv
// Directed self-checking bench for bus_slave_mem.
// Covers WAIT_CYCLES=2 and WAIT_CYCLES=0 instances side by side.
module tb_bus_slave_mem;

  logic        clk;
  logic        rst_n;
  logic        req, wr_en;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic        gnt;
  logic [31:0] rdata;
  logic        req0, wr_en0;
  logic [7:0]  addr0;
  logic [31:0] wdata0;
  logic        gnt0;
  logic [31:0] rdata0;
`ifdef BUS_SLAVE_MEM_STATS_EN
  logic [15:0] rd_cnt, wr_cnt, rd_cnt0, wr_cnt0;
`endif

  int checks;
  int failures;

  bus_slave_mem #(.DEPTH(64), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .addr(addr),
    .wdata(wdata), .wr_en(wr_en), .gnt(gnt), .rdata(rdata)
`ifdef BUS_SLAVE_MEM_STATS_EN
    , .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
`endif
  );

  bus_slave_mem #(.DEPTH(64), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .addr(addr0),
    .wdata(wdata0), .wr_en(wr_en0), .gnt(gnt0), .rdata(rdata0)
`ifdef BUS_SLAVE_MEM_STATS_EN
    , .rd_cnt(rd_cnt0), .wr_cnt(wr_cnt0)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("%s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one transfer; returns read data and grant latency in cycles.
  task automatic xfer(input bit z, input logic w, input logic [7:0] a,
                      input logic [31:0] d, output logic [31:0] rd,
                      output int cyc);
    bit got;
    got = 1'b0;
    cyc = 0;
    rd  = '0;
    @(posedge clk);
    #1;
    if (z) begin
      req0 = 1'b1; wr_en0 = w; addr0 = a; wdata0 = d;
    end else begin
      req = 1'b1; wr_en = w; addr = a; wdata = d;
    end
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (z ? gnt0 : gnt) begin
        got = 1'b1;
        rd  = z ? rdata0 : rdata;
      end
    end
    if (z) req0 = 1'b0;
    else   req  = 1'b0;
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL gnt_timeout addr=%h observed=0 expected=1", a);
    end
  endtask

  logic [31:0] rd;
  int          lat;

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    req = 0; wr_en = 0; addr = 0; wdata = 0;
    req0 = 0; wr_en0 = 0; addr0 = 0; wdata0 = 0;
    #2;
    chk("rst_gnt", {31'd0, gnt}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_gnt0", {31'd0, gnt0}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // write then read back with two wait states
    xfer(0, 1'b1, 8'h05, 32'hA5A5_0001, rd, lat);
    chk("wr05_lat", 32'(lat), 32'd3);
    @(negedge clk);
    chk("gnt_one_cycle", {31'd0, gnt}, 32'd0);
    xfer(0, 1'b0, 8'h05, 32'h0, rd, lat);
    chk("rd05_lat", 32'(lat), 32'd3);
    chk("rd05_data", rd, 32'hA5A5_0001);

    // write leaves rdata alone
    xfer(0, 1'b1, 8'h06, 32'hCAFE_0006, rd, lat);
    chk("wr_keeps_rdata", rdata, 32'hA5A5_0001);

    // out-of-range and boundary addresses
    xfer(0, 1'b1, 8'h40, 32'h1234_5678, rd, lat);
    chk("wr40_lat", 32'(lat), 32'd3);
    xfer(0, 1'b0, 8'h40, 32'h0, rd, lat);
    chk("rd40_data", rd, 32'hDEAD_BEEF);
    xfer(0, 1'b0, 8'h00, 32'h0, rd, lat);
    chk("rd00_data", rd, 32'h0);
    xfer(0, 1'b1, 8'h3F, 32'h3F3F_0000, rd, lat);
    xfer(0, 1'b0, 8'h3F, 32'h0, rd, lat);
    chk("rd3f_data", rd, 32'h3F3F_0000);
    xfer(0, 1'b0, 8'hFF, 32'h0, rd, lat);
    chk("rdff_data", rd, 32'hDEAD_BEEF);

    // req dropped in the second wait cycle
    @(posedge clk);
    #1;
    req = 1'b1; wr_en = 1'b1; addr = 8'h02; wdata = 32'hBAD0_0002;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_gnt", {31'd0, gnt}, 32'd0);
    end
    xfer(0, 1'b0, 8'h02, 32'h0, rd, lat);
    chk("rd02_after_abort", rd, 32'h0);

    // reset in the middle of a write's wait phase
    xfer(0, 1'b0, 8'h05, 32'h0, rd, lat);
    chk("rd05_pre_reset", rd, 32'hA5A5_0001);
    @(posedge clk);
    #1;
    req = 1'b1; wr_en = 1'b1; addr = 8'h03; wdata = 32'h3333_3333;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_gnt", {31'd0, gnt}, 32'd0);
    chk("midrst_rdata", rdata, 32'd0);
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    xfer(0, 1'b0, 8'h03, 32'h0, rd, lat);
    chk("rd03_lat_after_rst", 32'(lat), 32'd3);
    chk("rd03_after_rst", rd, 32'h0);
    xfer(0, 1'b0, 8'h05, 32'h0, rd, lat);
    chk("rd05_cleared", rd, 32'h0);

    // zero wait states, back-to-back reads with req held
    @(posedge clk);
    #1;
    req0 = 1'b1; wr_en0 = 1'b0; addr0 = 8'h00;
    @(posedge clk);
    @(negedge clk);
    chk("b2b_gnt_c1", {31'd0, gnt0}, 32'd1);
    chk("b2b_rdata_c1", rdata0, 32'h0);
    addr0 = 8'h01;
    @(posedge clk);
    @(negedge clk);
    chk("b2b_idle_c2", {31'd0, gnt0}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("b2b_gnt_c3", {31'd0, gnt0}, 32'd1);
    chk("b2b_rdata_c3", rdata0, 32'h0);
    req0 = 1'b0;
    xfer(1, 1'b1, 8'h01, 32'h0000_0011, rd, lat);
    chk("wc0_wr_lat", 32'(lat), 32'd1);
    xfer(1, 1'b0, 8'h01, 32'h0, rd, lat);
    chk("wc0_rd_data", rd, 32'h0000_0011);

`ifdef BUS_SLAVE_MEM_STATS_EN
    xfer(0, 1'b1, 8'h10, 32'h1, rd, lat);
    xfer(0, 1'b1, 8'h11, 32'h2, rd, lat);
    xfer(0, 1'b1, 8'h80, 32'h3, rd, lat);
    chk("stats_wr", {16'd0, wr_cnt}, 32'd3);
    chk("stats_rd", {16'd0, rd_cnt}, 32'd2);
    @(negedge clk);
    dut0.wr_cnt_q = 16'hFFFD;
    for (int i = 0; i < 4; i++) begin
      xfer(1, 1'b1, 8'h20, 32'(i), rd, lat);
    end
    chk("stats_wr_sat", {16'd0, wr_cnt0}, 32'h0000_FFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
